memory_bus_arbiter: RTL
=======================

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: SRC_W, 2, source-ID width, equal to clog2(NUM_REQ).
REQ-003 Parameter: TIMEOUT, 1024, maximum read-response wait in cycles (16-bit counter).
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset_n  in  1  reset, synchronous and active-low.
REQ-006 Port: req_valid  in  NUM_REQ  per-requester request pending; held until req_ready pulse.
REQ-007 Port: req_type  in  2*NUM_REQ  per-requester packet type: 1 = write, 2 = read, others illegal.
REQ-008 Port: req_addr  in  64*NUM_REQ  per-requester byte address.
REQ-009 Port: req_data  in  64*NUM_REQ  per-requester write payload.
REQ-010 Port: req_ready  out  NUM_REQ  one-cycle acceptance pulse, one-hot or zero.
REQ-011 Port: rsp_valid  out  NUM_REQ  one-cycle read-response pulse, one-hot or zero.
REQ-012 Port: rsp_data  out  64  read payload, valid with rsp_valid.
REQ-013 Port: mem_req_valid  out  1  packet offered to memory.
REQ-014 Port: mem_req_ready  in  1  memory accepts the packet this cycle.
REQ-015 Port: mem_req_type / mem_req_addr / mem_req_data / mem_req_source  out  2/64/64/SRC_W  latched packet fields.
REQ-016 Port: mem_rsp_valid / mem_rsp_data / mem_rsp_source  in  1/64/SRC_W  memory read response.
REQ-017 Port: error  out  1  sticky error flag, cleared only by reset.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_RSP; at most one transaction is outstanding.
REQ-019 IDLE: when any req_valid is high at a clock edge, the block grants the first set bit, searching upward from (last_grant+1) mod NUM_REQ and wrapping.
REQ-020 On grant, the block latches type, addr, data, and grant index g, sets last_grant=g, and pulses req_ready[g] high for exactly the next cycle.
REQ-021 On a legal grant, the FSM enters ISSUE, and mem_req_valid rises in the same cycle as req_ready[g]; the fields are driven from the latched values, and mem_req_source=g.
REQ-022 On an illegal type (0 or 3), req_ready[g] still pulses, no memory packet is issued, error is set, and the FSM stays IDLE.
REQ-023 ISSUE: mem_req_valid and all fields stay stable until a cycle with mem_req_ready=1; at that edge, a write returns to IDLE and a read enters WAIT_RSP.
REQ-024 WAIT_RSP: mem_rsp_valid with mem_rsp_source==g produces rsp_valid[g] and rsp_data=mem_rsp_data, both registered, for one cycle next; the FSM returns to IDLE.
REQ-025 WAIT_RSP: mem_rsp_valid with mem_rsp_source!=g sets error, discards the response, and the FSM keeps waiting.
REQ-026 WAIT_RSP watchdog: the counter clears on entry and increments each cycle; on reaching TIMEOUT-1 without a match, it sets error and returns to IDLE with no rsp_valid.
REQ-027 mem_rsp_valid in IDLE or ISSUE sets error and is otherwise ignored.
REQ-028 Minimum latency: req_valid seen at edge n gives req_ready/mem_req_valid in cycle n+1; with mem_req_ready=1 then, a write is back in IDLE at n+2.
REQ-029 Read round trip: rsp_valid occurs exactly one cycle after the matching mem_rsp_valid.
REQ-030 A requester shall drop or replace req_valid in the cycle after its req_ready; the IDLE re-sample at n+2 therefore sees its next request, if any.
REQ-031 Round-robin fairness: with all NUM_REQ requesting continuously, grants shall follow 0,1,2,3,0,... with no requester starved beyond NUM_REQ-1 grants.
REQ-032 req_ready, rsp_valid and mem_req_valid are never asserted in the same cycle as reset_n=0 sampled.

Reset
REQ-033 With reset_n low at an edge, state=IDLE, last_grant=NUM_REQ-1, and the watchdog=0.
REQ-034 Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mem_req_valid=0, all mem_req_* fields=0, error=0.
REQ-035 Reset mid-transaction abandons it silently; a stale mem_rsp_valid after reset sets error per REQ-027.

Verification
REQ-036 Reset, then req_valid=4'b0001 write addr 0x100 data 0x1122334455667788, mem_req_ready=1 -> req_ready[0] and mem_req_valid pulse for one cycle with those fields and source=0; IDLE two cycles after the request.
REQ-037 Read from requester 2 at addr 0x40, memory answers source=2 data 0xDEADBEEF three cycles later -> rsp_valid=4'b0100 and rsp_data=0xDEADBEEF one cycle after mem_rsp_valid; error=0.
REQ-038 req_valid=4'b1111 held with writes and mem_req_ready=1 -> grant order 0,1,2,3,0, one grant per two cycles.
REQ-039 mem_req_ready held low for 5 cycles -> mem_req_valid and fields stay constant for 5 cycles, and no new req_ready pulses.
REQ-040 Read pending for requester 1, response with source=3 -> error=1, no rsp_valid; correct source=1 response afterwards -> rsp_valid[1].
REQ-041 Read with no response, TIMEOUT=16 -> error=1 and return to IDLE 16 cycles after WAIT_RSP entry; req_type=3 request -> req_ready pulse, no mem_req_valid, error=1.

Source files
------------

// File: rtl/memory_bus_arbiter_if.sv
// rtl/memory_bus_arbiter_if.sv - request, response and memory-side bus bundle for memory_bus_arbiter
// Ports (signal groups):
//   req_valid/req_type/req_addr/req_data/req_ready  per-requester request channel (packed, slot k at [w*k +: w])
//   rsp_valid/rsp_data                              per-requester read-response pulse and shared payload
//   mem_req_valid/ready/type/addr/data/source       packet channel towards memory
//   mem_rsp_valid/data/source                       read response from memory
// Modports: slave = arbiter view, master = requester/memory environment view.
interface memory_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_type;
  logic [64*NUM_REQ-1:0] req_addr;
  logic [64*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [63:0]           rsp_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [1:0]            mem_req_type;
  logic [63:0]           mem_req_addr;
  logic [63:0]           mem_req_data;
  logic [SRC_W-1:0]      mem_req_source;
  logic                  mem_rsp_valid;
  logic [63:0]           mem_rsp_data;
  logic [SRC_W-1:0]      mem_rsp_source;

  modport slave (
    input  req_valid, req_type, req_addr, req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_source,
    output req_ready, rsp_valid, rsp_data,
    output mem_req_valid, mem_req_type, mem_req_addr, mem_req_data, mem_req_source
  );

  modport master (
    output req_valid, req_type, req_addr, req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_source,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_req_valid, mem_req_type, mem_req_addr, mem_req_data, mem_req_source
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin arbiter funnelling NUM_REQ requesters onto one memory port
// Ports:
//   clk      single clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      memory_bus_arbiter_if.slave: requester channels, response pulses, memory packet/response
//   error    sticky error flag (illegal type, stray/mismatched response, read timeout)
module memory_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  memory_bus_arbiter_if.slave bus,
  output logic                error
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t             state, state_next;
  logic [SRC_W-1:0]   last_grant;
  logic [15:0]        watchdog;

  logic               hi_found, lo_found, grant_found;
  logic [SRC_W-1:0]   hi_idx, lo_idx, grant_idx;
  logic [1:0]         sel_type;
  logic [63:0]        sel_addr, sel_data;
  logic [NUM_REQ-1:0] grant_onehot, src_onehot;

  logic               do_grant, grant_legal, accept, rsp_match, timeout_hit, err_set;

  // Round-robin pick: the lowest requester above last_grant wins, otherwise
  // the lowest one at or below it (the wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j]) begin
        if (j > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = SRC_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SRC_W'(j);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_type     = '0;
    sel_addr     = '0;
    sel_data     = '0;
    grant_onehot = '0;
    src_onehot   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_onehot[j] = (grant_idx == SRC_W'(j));
      src_onehot[j]   = (bus.mem_req_source == SRC_W'(j));
      if (grant_idx == SRC_W'(j)) begin
        sel_type = bus.req_type[2*j +: 2];
        sel_addr = bus.req_addr[64*j +: 64];
        sel_data = bus.req_data[64*j +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    do_grant    = 1'b0;
    grant_legal = 1'b0;
    accept      = 1'b0;
    rsp_match   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        // While a req_ready pulse is out the requester still shows the request
        // it just had accepted; skipping that cycle avoids a double grant.
        if (grant_found && (bus.req_ready == '0)) begin
          do_grant = 1'b1;
          if ((sel_type == 2'd1) || (sel_type == 2'd2)) begin
            grant_legal = 1'b1;
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          accept     = 1'b1;
          state_next = (bus.mem_req_type == 2'd2) ? WAIT_RSP : IDLE;
        end
      end
      WAIT_RSP: begin
        if (bus.mem_rsp_valid && (bus.mem_rsp_source == bus.mem_req_source)) begin
          rsp_match  = 1'b1;
          state_next = IDLE;
        end else if (watchdog == 16'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    err_set = (bus.mem_rsp_valid && !rsp_match) || timeout_hit || (do_grant && !grant_legal);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant         <= SRC_W'(NUM_REQ - 1);
      watchdog           <= '0;
      error              <= 1'b0;
      bus.req_ready      <= '0;
      bus.rsp_valid      <= '0;
      bus.rsp_data       <= '0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_type   <= '0;
      bus.mem_req_addr   <= '0;
      bus.mem_req_data   <= '0;
      bus.mem_req_source <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      if (err_set) error <= 1'b1;
      if (do_grant) begin
        bus.req_ready      <= grant_onehot;
        last_grant         <= grant_idx;
        bus.mem_req_valid  <= grant_legal;
        bus.mem_req_type   <= sel_type;
        bus.mem_req_addr   <= sel_addr;
        bus.mem_req_data   <= sel_data;
        bus.mem_req_source <= grant_idx;
      end
      if (accept) begin
        bus.mem_req_valid <= 1'b0;
        watchdog          <= '0;
      end
      if (state == WAIT_RSP) watchdog <= watchdog + 16'd1;
      if (rsp_match) begin
        bus.rsp_valid <= src_onehot;
        bus.rsp_data  <= bus.mem_rsp_data;
      end
    end
  end
endmodule
